// File: rtl/phv_pkg.sv
// Shared definitions for the multicast distributor: parameter defaults and the
// queue-bitmap extraction helper.
package phv_pkg;

    localparam int unsigned PhvLenDefault  = 1124;
    localparam int unsigned QmapOffDefault = 141;
    localparam int unsigned MaxQueues      = 16;

    // Takes the bitmap window (already aligned to bit 0) and clears every bit at or
    // above num_queues, so callers can zero-extend a narrower slice safely.
    function automatic logic [MaxQueues-1:0] qmap_extract(
        input logic [MaxQueues-1:0] window,
        input int unsigned          num_queues
    );
        logic [MaxQueues-1:0] qmap;
        for (int unsigned i = 0; i < MaxQueues; i++) begin
            qmap[i] = window[i] & (i < num_queues);
        end
        return qmap;
    endfunction

endpackage

// File: rtl/phv_queue_fifo.sv
// Single output-queue FIFO: registered output, no fall-through, power-of-2 depth.
module phv_queue_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic [Width-1:0] mem_q [Depth];
    logic             push_en, pop_en;

    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset; data is only observed while valid.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/phv_mcast_dist.sv
// Multicast distributor: copies each accepted PHV into every queue named by its
// bitmap, all-or-nothing, and counts PHVs dropped for having an empty bitmap.
module phv_mcast_dist
    import phv_pkg::*;
#(
    parameter int unsigned PHV_LEN      = PhvLenDefault,
    parameter int unsigned C_NUM_QUEUES = 4,
    parameter int unsigned QMAP_OFF     = QmapOffDefault,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                            axis_clk,
    input  logic                            areset,
    input  logic [PHV_LEN-1:0]              phv_in,
    input  logic                            phv_in_valid,
    output logic                            phv_in_ready,
    output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
    output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0]         phv_out_ready,
    output logic [CNT_WIDTH-1:0]            drop_cnt
);

    logic [MaxQueues-1:0]    qmap_all;
    logic [C_NUM_QUEUES-1:0] dest, full, empty, push, pop;
    logic                    accept, drop;
    logic                    unused_qmap;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

    assign qmap_all    = qmap_extract(MaxQueues'(phv_in[QMAP_OFF +: C_NUM_QUEUES]), C_NUM_QUEUES);
    assign dest        = qmap_all[C_NUM_QUEUES-1:0];
    assign unused_qmap = ^qmap_all;

    // Ready looks only at full flags of the selected queues, never at valid.
    assign phv_in_ready = &(~dest | ~full);
    assign accept       = phv_in_valid & phv_in_ready;
    assign push         = {C_NUM_QUEUES{accept}} & dest;
    assign drop         = accept & ~|dest;

    assign phv_out_valid = ~empty;
    assign pop           = phv_out_valid & phv_out_ready;

    for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_queue
        phv_queue_fifo #(
            .Depth(BUF_DEPTH),
            .Width(PHV_LEN)
        ) u_fifo (
            .clk_i  (axis_clk),
            .rst_i  (areset),
            .push_i (push[q]),
            .data_i (phv_in),
            .pop_i  (pop[q]),
            .data_o (phv_out[q*PHV_LEN +: PHV_LEN]),
            .full_o (full[q]),
            .empty_o(empty[q])
        );
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/phv_mcast_dist.md
# phv_mcast_dist

Parametrised multicast distributor at the tail of the last pipeline stage: takes the action-engine PHV, decodes its queue bitmap and buffers a copy into an independent per-queue FIFO for each set bit. Each output queue has its own valid/ready handshake, so a stalled queue back-pressures only PHVs destined for it. Queue count, bitmap position and buffer depth are generic, and empty-bitmap PHVs are dropped and counted.

## Interface
- `PHV_LEN`, 1124: PHV width in bits.
- `C_NUM_QUEUES`, 4: number of output queues, 1..16.
- `QMAP_OFF`, 141: LSB of the queue bitmap in the PHV. Bitmap is `phv_in[QMAP_OFF +: C_NUM_QUEUES]`, and bit q selects queue q.
- `BUF_DEPTH`, 4: per-queue FIFO depth. Must be a power of 2 and at least 2.
- `CNT_WIDTH`, 32: width of the drop counter.

Ports:
- `axis_clk` in 1: clock.
- `areset` in 1: reset, asynchronous and active-high.
- `phv_in` in PHV_LEN: PHV from the action engine.
- `phv_in_valid` in 1: input valid.
- `phv_in_ready` out 1: input ready.
- `phv_out` out C_NUM_QUEUES*PHV_LEN: queue q is on slice `[q*PHV_LEN +: PHV_LEN]`.
- `phv_out_valid` out C_NUM_QUEUES: per-queue valid.
- `phv_out_ready` in C_NUM_QUEUES: per-queue ready, driven by the downstream PHV FIFO.
- `drop_cnt` out CNT_WIDTH: count of dropped empty-bitmap PHVs, saturating.

## Operation
- `dest = phv_in[QMAP_OFF +: C_NUM_QUEUES]`.
- `full[q]` means occupancy of queue q equals BUF_DEPTH.
- `phv_in_ready = &(~dest | ~full)`.
  - Ready is a combinational function of the registered full flags and the input data only. It never depends on `phv_in_valid`.
  - An empty bitmap therefore always gives ready = 1.
- `accept = phv_in_valid & phv_in_ready`.
- On accept with `dest != 0`: for every q with `dest[q]`, write `phv_in` unmodified (bitmap left intact) into FIFO q. All selected queues are written in the same cycle, so a PHV is all-or-nothing across its queues.
- On accept with `dest == 0`: no write; `drop_cnt` increments by 1 and saturates at all-ones.
- Per-queue FIFO:
  - Storage is `BUF_DEPTH` entries.
  - Read and write pointers are `log2(BUF_DEPTH)` bits and wrap naturally at BUF_DEPTH-1 → 0.
  - Occupancy counter is `log2(BUF_DEPTH)+1` bits.
- `phv_out_valid[q] = (occupancy[q] != 0)`.
- `phv_out` slice q is `mem_q[rd_ptr_q]`. It is stable while valid is high and ready is low.
- A pop of queue q happens when `phv_out_valid[q] & phv_out_ready[q]`.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When the queue is full, the push is already blocked by ready, so only the pop occurs. There is no same-cycle pass-through of freed space.
- Push into an empty queue gives valid the next cycle. There is no fall-through.
- Reset, asynchronous assert (including mid-transfer):
  - All pointers and occupancies are cleared and any buffered PHVs are discarded.
  - `phv_out_valid = 0` and `drop_cnt = 0`.
  - `phv_in_ready` reads 1, since all queues are empty.
  - Memory contents are not reset, and `phv_out` data is don't-care while valid is 0.
- Reset is released synchronously by the existing top-level reset synchroniser.

## Timing
- Latency from input accept to `phv_out_valid[q]` is 1 cycle.
- Each queue sustains 1 PHV/cycle when its ready is held high.
- Input throughput is 1 PHV/cycle while no selected queue is full.
- A queue that goes from full to not-full through a pop in cycle N is usable by the input in cycle N+1.
- `drop_cnt` updates 1 cycle after the dropping accept.
- All outputs are registered or decoded from registers, except `phv_in_ready`, which has an input-data path of one AND-OR level.

## Structure
- Shared package `phv_pkg` holds:
  - `PHV_LEN` and `QMAP_OFF` defaults.
  - The C_NUM_QUEUES upper bound.
  - A queue-bitmap extraction function.
- One sub-module, `phv_queue_fifo` (depth BUF_DEPTH, width PHV_LEN, push/pop/full/empty), instantiated C_NUM_QUEUES times in a generate loop.
- Top level holds the dest decode, ready/accept logic and drop counter.

## Test plan
All scenarios use C_NUM_QUEUES=4, BUF_DEPTH=4.

1. Reset values: after reset, `phv_out_valid=4'b0000`, `drop_cnt=0`, `phv_in_ready=1`. Assert reset while queue 0 holds 3 entries → queue 0 valid drops immediately (asynchronously) and the entries are never emitted.
2. Unicast and multicast fan-out: send a PHV with bitmap 4'b0001, then 4'b1010, with all readies high → queue 0 gets the PHV at +1 cycle. Queues 1 and 3 get the second PHV in the same cycle, with data bit-identical to the input.
3. Per-queue back-pressure: hold `phv_out_ready[2]=0` and push 4 PHVs with bitmap 4'b0100 → queue 2 is full. A 5th PHV with 4'b0100 sees ready=0, while a PHV with 4'b0001 is accepted the same cycle. Raise `ready[2]` → the 5th PHV is accepted the next cycle.
4. All-or-nothing multicast: with queue 3 full, offer bitmap 4'b1001 → not accepted, and nothing is written to queue 0 either.
5. Drop path: 3 PHVs with bitmap 4'b0000 → all accepted with no output valid, and `drop_cnt=3`. Preload the counter near its maximum (CNT_WIDTH=4 build, 16 drops) → `drop_cnt` stays at 15.
6. Wrap-around and simultaneous push/pop: stream 20 PHVs with ascending payload to queue 1 while its ready toggles 1/0 → the output order matches the input order exactly, and occupancy never exceeds 4.
